// File: rtl/axi_burst_to_fifo_pkg.sv
// Shared types and constants for the single-shot AXI read-burst-to-FIFO mover.
package axi_burst_pkg;

    localparam int unsigned DEF_ADDR_W = 16;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LEN_W  = 8;

    localparam logic [2:0] DEF_ARSIZE     = 3'd5;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        LOAD,
        AR,
        RDATA,
        DONE
    } state_t;

endpackage

// File: rtl/axi_burst_to_fifo_if.sv
// AXI4 master read/write channels plus FIFO write/read ports used by axi_burst_to_fifo.
interface axi_burst_to_fifo_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned LEN_W  = 8
);
    logic [ADDR_W-1:0]   s_axi_araddr;
    logic [LEN_W-1:0]    s_axi_arlen;
    logic [2:0]          s_axi_arsize;
    logic [1:0]          s_axi_arburst;
    logic                s_axi_arvalid;
    logic                s_axi_arready;
    logic [DATA_W-1:0]   s_axi_rdata;
    logic                s_axi_rvalid;
    logic                s_axi_rready;

    logic [ADDR_W-1:0]   s_axi_awaddr;
    logic [LEN_W-1:0]    s_axi_awlen;
    logic [2:0]          s_axi_awsize;
    logic [1:0]          s_axi_awburst;
    logic                s_axi_awvalid;
    logic                s_axi_awready;
    logic [DATA_W-1:0]   s_axi_wdata;
    logic [DATA_W/8-1:0] s_axi_wstrb;
    logic                s_axi_wlast;
    logic                s_axi_wvalid;
    logic                s_axi_wready;
    logic                s_axi_bvalid;
    logic                s_axi_bready;

    logic [DATA_W-1:0]   fifo_in_data;
    logic                fifo_write_valid;
    logic                fifo_write_ready;
    logic                fifo_read_valid;
    logic [DATA_W-1:0]   fifo_out_data;
    logic                fifo_read_ready;

    modport master (
        output s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        output s_axi_rready,
        output s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
        output fifo_in_data, fifo_write_valid, fifo_read_valid,
        input  s_axi_arready, s_axi_rdata, s_axi_rvalid,
        input  s_axi_awready, s_axi_wready, s_axi_bvalid,
        input  fifo_write_ready, fifo_out_data, fifo_read_ready
    );

    modport slave (
        input  s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
        input  s_axi_rready,
        input  s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
        input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid, s_axi_bready,
        input  fifo_in_data, fifo_write_valid, fifo_read_valid,
        output s_axi_arready, s_axi_rdata, s_axi_rvalid,
        output s_axi_awready, s_axi_wready, s_axi_bvalid,
        output fifo_write_ready, fifo_out_data, fifo_read_ready
    );

endinterface

// File: rtl/axi_burst_to_fifo_beat_counter.sv
// Beat counter for the read burst; last flags the final beat, with len=0 treated as one beat.
module axi_beat_counter #(
    parameter int unsigned LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             beat,
    input  logic [LEN_W-1:0] len,
    output logic             last
);

    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W:0]   cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Widened compare so cnt+1 never wraps; len=0 makes last true on the first beat.
    always_comb begin
        cnt_inc = {1'b0, cnt_q} + {{LEN_W{1'b0}}, 1'b1};
        last    = (cnt_inc >= {1'b0, len});
    end

endmodule

// File: rtl/axi_burst_to_fifo.sv
// Single-shot AXI4 INCR read burst into a FIFO write port; valid latches high when done.
// Optional AXI_BURST_STATS_EN adds a saturating stall_cycles counter output.
module axi_burst_to_fifo
    import axi_burst_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    parameter logic [2:0]  ARSIZE = DEF_ARSIZE
) (
    input  logic              clk,
    input  logic              rst,
    output logic [LEN_W-1:0]  len_raddr,
    output logic [LEN_W-1:0]  len_waddr,
    output logic [LEN_W-1:0]  len_wdata,
    output logic              len_wen,
    input  logic [LEN_W-1:0]  len_rdata,
    output logic [ADDR_W-1:0] addr_raddr,
    output logic [ADDR_W-1:0] addr_waddr,
    output logic [ADDR_W-1:0] addr_wdata,
    output logic              addr_wen,
    input  logic [ADDR_W-1:0] addr_rdata,
    axi_burst_to_fifo_if.master bus,
`ifdef AXI_BURST_STATS_EN
    output logic [15:0]       stall_cycles,
`endif
    output logic              valid
);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] addr_q;
    logic              beat, last;
    logic              arvalid, rready, fifo_wvalid, done;
    logic [DATA_W-1:0] fifo_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD;
            len_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == LOAD) begin
                len_q  <= len_rdata;
                addr_q <= addr_rdata;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        beat        = 1'b0;
        arvalid     = 1'b0;
        rready      = 1'b0;
        fifo_wvalid = 1'b0;
        fifo_wdata  = '0;
        done        = 1'b0;
        unique case (state_q)
            LOAD: state_d = AR;
            AR: begin
                arvalid = 1'b1;
                if (bus.s_axi_arready) state_d = RDATA;
            end
            RDATA: begin
                rready      = bus.fifo_write_ready;
                fifo_wvalid = bus.s_axi_rvalid;
                fifo_wdata  = bus.s_axi_rdata;
                beat        = bus.s_axi_rvalid && bus.fifo_write_ready;
                if (beat && last) state_d = DONE;
            end
            DONE: done = 1'b1;
            default: state_d = LOAD;
        endcase
    end

    axi_beat_counter #(
        .LEN_W (LEN_W)
    ) u_beat_counter (
        .clk  (clk),
        .rst  (rst),
        .beat (beat),
        .len  (len_q),
        .last (last)
    );

`ifdef AXI_BURST_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
        end else if (state_q == RDATA && bus.s_axi_rvalid && !bus.fifo_write_ready &&
                     stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

    // Config memories are read-only here, always at address 0.
    assign len_raddr  = '0;
    assign len_waddr  = '0;
    assign len_wdata  = '0;
    assign len_wen    = 1'b0;
    assign addr_raddr = '0;
    assign addr_waddr = '0;
    assign addr_wdata = '0;
    assign addr_wen   = 1'b0;

    assign bus.s_axi_araddr  = addr_q;
    assign bus.s_axi_arlen   = len_q;
    assign bus.s_axi_arsize  = ARSIZE;
    assign bus.s_axi_arburst = AXI_BURST_INCR;
    assign bus.s_axi_arvalid = arvalid;
    assign bus.s_axi_rready  = rready;

    assign bus.s_axi_awaddr  = '0;
    assign bus.s_axi_awlen   = '0;
    assign bus.s_axi_awsize  = '0;
    assign bus.s_axi_awburst = '0;
    assign bus.s_axi_awvalid = 1'b0;
    assign bus.s_axi_wdata   = '0;
    assign bus.s_axi_wstrb   = '0;
    assign bus.s_axi_wlast   = 1'b0;
    assign bus.s_axi_wvalid  = 1'b0;
    assign bus.s_axi_bready  = 1'b0;

    assign bus.fifo_in_data     = fifo_wdata;
    assign bus.fifo_write_valid = fifo_wvalid;
    assign bus.fifo_read_valid  = 1'b0;
    assign valid                = done;

    logic unused_inputs;
    assign unused_inputs = ^{bus.s_axi_awready, bus.s_axi_wready, bus.s_axi_bvalid,
                             bus.fifo_out_data, bus.fifo_read_ready};

endmodule

// File: tb/tb_axi_burst_to_fifo.sv
// Randomized scoreboard bench for axi_burst_to_fifo; stats checks follow AXI_BURST_STATS_EN.
module tb_axi_burst_to_fifo;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int LW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [LW-1:0] len_raddr, len_waddr, len_wdata, len_rdata;
    logic          len_wen;
    logic [AW-1:0] addr_raddr, addr_waddr, addr_wdata, addr_rdata;
    logic          addr_wen;
    logic          valid;
`ifdef AXI_BURST_STATS_EN
    logic [15:0]   stall_cycles;
`endif

    axi_burst_to_fifo_if #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

    axi_burst_to_fifo #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .ARSIZE(3'd5)) dut (
        .clk          (clk),
        .rst          (rst),
        .len_raddr    (len_raddr),
        .len_waddr    (len_waddr),
        .len_wdata    (len_wdata),
        .len_wen      (len_wen),
        .len_rdata    (len_rdata),
        .addr_raddr   (addr_raddr),
        .addr_waddr   (addr_waddr),
        .addr_wdata   (addr_wdata),
        .addr_wen     (addr_wen),
        .addr_rdata   (addr_rdata),
        .bus          (bus),
`ifdef AXI_BURST_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .valid        (valid)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] exp_q[$];
    int got_beats   = 0;
    int stall_model = 0;
    bit in_rdata    = 1'b0;
    bit done_chk    = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input string act, input string req);
        checks++;
        errors++;
        $display("FAIL %s actual=%s required=%s", name, act, req);
    endtask

    // Monitor: pops the scoreboard on each FIFO write and checks RDATA/DONE behaviour.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_chk) begin
                chk("valid_after_last", valid, 1);
                done_chk = 1'b0;
            end
            if (bus.fifo_write_valid && bus.fifo_write_ready) begin
                chk("valid_low_during_beat", valid, 0);
                if (exp_q.size() == 0) fail_now("extra_beat", "write", "none");
                else begin
                    chk("beat_data", bus.fifo_in_data, exp_q.pop_front());
                    if (exp_q.size() == 0) done_chk = 1'b1;
                end
                got_beats++;
            end
            if (in_rdata && !valid) begin
                chk("rready_mirror", bus.s_axi_rready, bus.fifo_write_ready);
                chk("wvalid_mirror", bus.fifo_write_valid, bus.s_axi_rvalid);
                chk("arvalid_in_rdata", bus.s_axi_arvalid, 0);
                if (bus.s_axi_rvalid && !bus.fifo_write_ready) stall_model++;
            end
            if (valid) begin
                chk("done_rready", bus.s_axi_rready, 0);
                chk("done_wvalid", bus.fifo_write_valid, 0);
                chk("done_arvalid", bus.s_axi_arvalid, 0);
            end
        end
    end

    task automatic check_reset_outputs();
        chk("rst_arvalid", bus.s_axi_arvalid, 0);
        chk("rst_rready", bus.s_axi_rready, 0);
        chk("rst_fifo_wvalid", bus.fifo_write_valid, 0);
        chk("rst_fifo_data", bus.fifo_in_data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_araddr", bus.s_axi_araddr, 0);
        chk("rst_arlen", bus.s_axi_arlen, 0);
        chk("rst_arsize", bus.s_axi_arsize, 5);
        chk("rst_arburst", bus.s_axi_arburst, 1);
        chk("rst_tieoffs", |{bus.s_axi_awaddr, bus.s_axi_awlen, bus.s_axi_awsize,
                             bus.s_axi_awburst, bus.s_axi_awvalid, bus.s_axi_wdata,
                             bus.s_axi_wstrb, bus.s_axi_wlast, bus.s_axi_wvalid,
                             bus.s_axi_bready, bus.fifo_read_valid}, 0);
        chk("rst_mem_ports", |{len_raddr, len_waddr, len_wdata, len_wen,
                               addr_raddr, addr_waddr, addr_wdata, addr_wen}, 0);
`ifdef AXI_BURST_STATS_EN
        chk("rst_stall_cycles", stall_cycles, 0);
`endif
    endtask

    task automatic do_reset(input logic [LW-1:0] len, input logic [AW-1:0] addr);
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_rdata = 1'b0;
        bus.s_axi_rvalid = 1'b0;
        bus.s_axi_arready = 1'b0;
        len_rdata = len;
        addr_rdata = addr;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        exp_q.delete();
        got_beats = 0;
        stall_model = 0;
        done_chk = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // mode: 0 ready high, 1 toggle, 2 random, 3 low for cycles 20..24 of the data phase.
    task automatic run_burst(input logic [LW-1:0] len, input logic [AW-1:0] addr,
                             input int ar_delay, input int rv_pct, input int mode,
                             input int init_gap, input int abort_after, input bit seq);
        int n;
        int seen;
        int b;
        int cyc;
        bit ok;
        bit acc;
        bit fin;
        bit hold;
        logic [DW-1:0] data[$];
        n = (len == 0) ? 1 : int'(len);
        for (int i = 0; i < n + 2; i++) data.push_back(seq ? DW'(32'hA0 + i) : DW'($urandom));
        bus.fifo_write_ready = 1'b1;
        do_reset(len, addr);
        for (int i = 0; i < n; i++) exp_q.push_back(data[i]);

        seen = 0;
        ok = 1'b0;
        for (int t = 0; t < 30 && !ok; t++) begin
            @(negedge clk);
            if (seen > 0) chk("arvalid_hold", bus.s_axi_arvalid, 1);
            if (bus.s_axi_arvalid) begin
                seen++;
                chk("araddr", bus.s_axi_araddr, addr);
                chk("arlen", bus.s_axi_arlen, len);
                chk("arsize", bus.s_axi_arsize, 5);
                chk("arburst", bus.s_axi_arburst, 1);
                chk("valid_before_ar", valid, 0);
                if (seen == ar_delay + 1) begin
                    bus.s_axi_arready = 1'b1;
                    @(posedge clk);
                    #1;
                    bus.s_axi_arready = 1'b0;
                    ok = 1'b1;
                end
            end
        end
        if (!ok) begin
            fail_now("ar_timeout", "no_handshake", "handshake");
            return;
        end

        in_rdata = 1'b1;
        b = 0;
        cyc = 0;
        hold = 1'b0;
        fin = 1'b0;
        forever begin
            case (mode)
                1: bus.fifo_write_ready = (cyc % 2 == 0);
                2: bus.fifo_write_ready = 1'($urandom % 2);
                3: bus.fifo_write_ready = !(cyc >= 20 && cyc < 25);
                default: bus.fifo_write_ready = 1'b1;
            endcase
            if (!hold) begin
                if (cyc >= init_gap && b < n + 2 && (abort_after == 0 || b < abort_after) &&
                    int'($urandom % 100) < rv_pct) begin
                    bus.s_axi_rvalid = 1'b1;
                    bus.s_axi_rdata = data[b];
                end else begin
                    bus.s_axi_rvalid = 1'b0;
                end
            end
            @(negedge clk);
            acc = bus.s_axi_rvalid && bus.s_axi_rready;
            fin = valid;
            @(posedge clk);
            #1;
            if (acc) b++;
            hold = bus.s_axi_rvalid && !acc;
            cyc++;
            if (fin || cyc > 20 * n + 200 || (abort_after != 0 && b >= abort_after)) break;
        end
        bus.s_axi_rvalid = 1'b0;
        in_rdata = 1'b0;

        if (abort_after != 0) begin
            chk("abort_beats", got_beats, abort_after);
            return;
        end
        chk("done_reached", fin, 1);
        chk("beat_count", got_beats, n);
        chk("scoreboard_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("valid_sticky", valid, 1);
`ifdef AXI_BURST_STATS_EN
        chk("stall_cycles", stall_cycles, stall_model);
`endif
    endtask

    initial begin
        bus.s_axi_arready = 1'b0;
        bus.s_axi_rvalid = 1'b0;
        bus.s_axi_rdata = '0;
        bus.s_axi_awready = 1'b0;
        bus.s_axi_wready = 1'b0;
        bus.s_axi_bvalid = 1'b0;
        bus.fifo_write_ready = 1'b1;
        bus.fifo_out_data = '0;
        bus.fifo_read_ready = 1'b0;
        len_rdata = '0;
        addr_rdata = '0;

        run_burst(8'd4, 16'h1000, 2, 100, 0, 0, 0, 1'b1);
        run_burst(8'd0, 16'h0040, 0, 100, 0, 0, 0, 1'b0);
        run_burst(8'd3, 16'h2222, 1, 100, 1, 0, 0, 1'b0);
        run_burst(8'd5, 16'h0abc, 0, 100, 0, 10, 0, 1'b0);
        run_burst(8'd4, 16'h2000, 0, 100, 0, 0, 1, 1'b0);
        run_burst(8'd2, 16'h3456, 1, 100, 0, 0, 0, 1'b0);
        run_burst(8'd255, 16'hfff0, 0, 100, 3, 0, 0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_burst(LW'($urandom % 20), AW'($urandom), int'($urandom % 4),
                      50 + int'($urandom % 51), 2, 0, 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_burst_to_fifo.md
Name: axi_burst_to_fifo

Overview:
- Single-shot AXI4 read-burst mover.
- After reset it fetches a burst length from an 8-bit config memory and a start address from a 16-bit config memory, then issues one INCR read burst on an AXI master read channel.
- It forwards every returned beat into a ready/valid FIFO write port, then asserts `valid` (done) permanently.
- Sits between a configuration scratchpad and a stream consumer.

Parameters:
- ADDR_W, 16, AXI address width and address-memory data width
- DATA_W, 32, AXI data width and FIFO data width
- LEN_W, 8, length-memory data width and arlen width
- ARSIZE, 3'd5, constant driven on s_axi_arsize

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- len_raddr/len_waddr/len_wdata  out  LEN_W  length memory ports; all driven 0
- len_wen  out  1  driven 0
- len_rdata  in  LEN_W  length word at address 0
- addr_raddr/addr_waddr/addr_wdata  out  ADDR_W  address memory ports; all driven 0
- addr_wen  out  1  driven 0
- addr_rdata  in  ADDR_W  start address at address 0
- s_axi_araddr  out  ADDR_W;  s_axi_arlen  out  LEN_W;  s_axi_arsize  out  3;  s_axi_arburst  out  2
- s_axi_arvalid  out  1;  s_axi_arready  in  1
- s_axi_rdata  in  DATA_W;  s_axi_rvalid  in  1;  s_axi_rready  out  1
- s_axi_aw*/w*/bready  out  tie-off, all 0;  s_axi_awready/wready/bvalid  in  ignored
- fifo_in_data  out  DATA_W;  fifo_write_valid  out  1;  fifo_write_ready  in  1
- fifo_read_valid  out  1  driven 0;  fifo_out_data/fifo_read_ready  in  ignored
- valid  out  1  done flag

Behaviour:
- Clock and reset: clk; synchronous active-high rst.
- Reset values: state=LOAD, beat counter=0, len_reg=0, addr_reg=0. All outputs 0 except constants: arburst=2'b01, arsize=ARSIZE.
- Config memories have 1-cycle read latency; read addresses are fixed at 0.
- LOAD (1 cycle): latch len_reg<=len_rdata, addr_reg<=addr_rdata -> AR.
- AR:
  - arvalid=1, araddr=addr_reg, arlen=len_reg.
  - Hold arvalid and all AR fields stable until arready.
  - On arvalid&&arready -> RDATA.
- RDATA:
  - rready=fifo_write_ready; fifo_write_valid=rvalid; fifo_in_data=rdata (combinational pass-through, zero latency).
  - A beat completes on rvalid&&fifo_write_ready; cnt<=cnt+1 (LEN_W wrap).
  - If cnt+1 >= len_reg (unsigned), go to DONE in the same edge.
  - Loop is do-while: len_reg=0 still transfers exactly 1 beat.
- DONE: valid=1 every cycle until rst; rready, fifo_write_valid and arvalid are 0.
- Beats transferred = max(len_reg,1). arlen carries len_reg verbatim (no -1 adjustment).
- Backpressure: if fifo_write_ready=0, rready=0 and rdata is not consumed; rvalid without ready causes no state change.
- rst mid-burst: returns to LOAD next edge; outstanding AXI beats are not drained (system-level reset required).
- arlen, araddr, arsize and arburst hold len_reg/addr_reg/constants in all states; only arvalid gates them.

Optional Feature:
- AXI_BURST_STATS_EN defined: adds output `stall_cycles` (16 bits). It counts RDATA cycles where rvalid=1 and fifo_write_ready=0, saturates at 16'hFFFF, and resets to 0.
- Macro undefined: port absent, no counter logic.

Decomposition:
- Package axi_burst_pkg:
  - state enum {LOAD, AR, RDATA, DONE}
  - AXI_BURST_INCR=2'b01
  - default widths
- Sub-module axi_beat_counter: holds cnt, increments on beat strobe, outputs last = (cnt+1 >= len) with min-1 rule. The top FSM instantiates it.

Test Plan:
- len_rdata=4, addr_rdata=16'h1000, arready after 2 cycles, rdata 0xA0..0xA3 back-to-back, fifo ready -> araddr=0x1000, arlen=4, arvalid held 3 cycles; 4 FIFO writes in order; valid=1 the cycle after the 4th beat.
- len=0 -> exactly 1 beat forwarded, then valid=1.
- len=3, fifo_write_ready toggles 1/0 with rvalid constant 1 -> rready mirrors ready; only 3 beats written; no duplicates or drops.
- rvalid=0 for 10 cycles in RDATA -> no writes, counter unchanged, valid=0.
- rst asserted mid-RDATA after 1 of 4 beats -> next cycle outputs at reset values; new LOAD resamples config.
- len=255 -> 255 beats, counter no overflow before DONE; with AXI_BURST_STATS_EN, 5 injected stall cycles -> stall_cycles=5.
